// File: rtl/snn_pkg.sv
// Shared definitions for the SNN timestep scheduler.
//   state_t         : scheduler FSM states
//   OUTPUTS_DEFAULT : default number of observed output neurons
//   COUNT_BITS_DEFAULT : default spike-counter width
//   WINNER_BITS     : index width of the winning class at default size
//   COUNT_MAX       : saturation value of a default-width counter
package snn_pkg;

  localparam int OUTPUTS_DEFAULT    = 8;
  localparam int COUNT_BITS_DEFAULT = 8;
  localparam int WINNER_BITS        = $clog2(OUTPUTS_DEFAULT);
  localparam int COUNT_MAX          = (1 << COUNT_BITS_DEFAULT) - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/snn_argmax.sv
// Combinational argmax over N packed unsigned counts.
//   counts : N*W bits, element i at [i*W +: W]
//   winner : index of the maximum; ties resolve to the lowest index
module snn_argmax
  import snn_pkg::*;
#(
  parameter int N     = OUTPUTS_DEFAULT,
  parameter int W     = COUNT_BITS_DEFAULT,
  parameter int IDX_W = WINNER_BITS
) (
  input  logic [N*W-1:0]   counts,
  output logic [IDX_W-1:0] winner
);

  logic [W-1:0] best;

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    best   = counts[W-1:0];
    winner = '0;
    for (int i = 1; i < N; i++) begin
      if (counts[i*W +: W] > best) begin
        best   = counts[i*W +: W];
        winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences one inference of the spiking network: pulses clear_state,
// runs execute for num_steps cycles, drains the inter-layer pipeline and
// rate-decodes the output layer into saturating per-neuron spike counts.
//   clk, reset (async, active-high)
//   start_valid/start_ready/num_steps : inference request handshake
//   abort        : cancel the current run (ignored in IDLE)
//   execute      : network enable, one timestep per cycle
//   clear_state  : one-cycle neuron/layer clear pulse
//   spikes       : output-layer spike vector
//   result_valid/result_ready : result handshake
//   spike_counts : neuron i at [i*COUNT_BITS +: COUNT_BITS]
//   winner       : lowest index holding the maximum count
//   busy         : scheduler not idle
module snn_timestep_scheduler
  import snn_pkg::*;
#(
  parameter int OUTPUTS    = OUTPUTS_DEFAULT,
  parameter int COUNT_BITS = COUNT_BITS_DEFAULT,
  parameter int STEPS_BITS = 8,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [STEPS_BITS-1:0]         num_steps,
  input  logic                          abort,
  output logic                          execute,
  output logic                          clear_state,
  input  logic [OUTPUTS-1:0]            spikes,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [OUTPUTS*COUNT_BITS-1:0] spike_counts,
  output logic [$clog2(OUTPUTS)-1:0]    winner,
  output logic                          busy
);

  localparam int WB = $clog2(OUTPUTS);
  localparam logic [COUNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [2:0]            DRAIN_END = 3'(PIPE_DEPTH - 1);

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t                  state;
  logic [STEPS_BITS-1:0]   steps_q;
  logic [STEPS_BITS-1:0]   step_cnt;
  logic [2:0]              drain_cnt;
  logic [PIPE_DEPTH-1:0]   exec_dly;
  logic                    sample_en;
  logic                    start_hs;
  logic                    abort_act;
  logic [COUNT_BITS-1:0]   cnt [OUTPUTS];

  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign start_hs    = start_valid & start_ready;
  assign abort_act   = abort & busy;
  // Spikes arrive PIPE_DEPTH cycles after the execute that caused them.
  assign sample_en   = exec_dly[PIPE_DEPTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      execute      <= 1'b0;
      clear_state  <= 1'b0;
      result_valid <= 1'b0;
      steps_q      <= '0;
      step_cnt     <= '0;
      drain_cnt    <= '0;
    end else begin
      clear_state <= 1'b0;
      if (abort_act) begin
        // Abort overrides every transition, including the DONE handshake.
        state        <= S_IDLE;
        execute      <= 1'b0;
        result_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_hs) begin
              steps_q  <= num_steps;
              step_cnt <= '0;
              if (num_steps == '0) begin
                state        <= S_DONE;
                result_valid <= 1'b1;
              end else begin
                state       <= S_CLEAR;
                clear_state <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            state   <= S_RUN;
            execute <= 1'b1;
          end
          S_RUN: begin
            step_cnt <= step_cnt + 1'b1;
            if (step_cnt == steps_q - 1'b1) begin
              state     <= S_DRAIN;
              execute   <= 1'b0;
              drain_cnt <= '0;
            end
          end
          S_DRAIN: begin
            if (drain_cnt == DRAIN_END) begin
              state        <= S_DONE;
              result_valid <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          S_DONE: begin
            if (result_ready) begin
              state        <= S_IDLE;
              result_valid <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // ---- sample stage: execute delay line and saturating counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_dly <= '0;
      for (int i = 0; i < OUTPUTS; i++) cnt[i] <= '0;
    end else begin
      if (abort_act) exec_dly <= '0;
      else           exec_dly <= (exec_dly << 1) | PIPE_DEPTH'(execute);
      for (int i = 0; i < OUTPUTS; i++) begin
        if (start_hs)                    cnt[i] <= '0;
        else if (sample_en && spikes[i]) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_flat
    assign spike_counts[g*COUNT_BITS +: COUNT_BITS] = cnt[g];
  end

  snn_argmax #(
    .N     (OUTPUTS),
    .W     (COUNT_BITS),
    .IDX_W (WB)
  ) u_argmax (
    .counts (spike_counts),
    .winner (winner)
  );

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
module tb_snn_timestep_scheduler;
  import snn_pkg::*;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid = 1'b0;
  logic        abort = 1'b0;
  logic        result_ready = 1'b0;
  logic [7:0]  num_steps = '0;
  logic [7:0]  spikes = '0;

  logic        start_ready, execute, clear_state, result_valid, busy;
  logic [63:0] spike_counts;
  logic [WINNER_BITS-1:0] winner;

  logic        s_start_ready, s_execute, s_clear_state, s_result_valid, s_busy;
  logic [31:0] s_spike_counts;
  logic [2:0]  s_winner;

  snn_timestep_scheduler #(.OUTPUTS(8), .COUNT_BITS(8), .STEPS_BITS(8), .PIPE_DEPTH(P)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .num_steps(num_steps), .abort(abort), .execute(execute), .clear_state(clear_state),
    .spikes(spikes), .result_valid(result_valid), .result_ready(result_ready),
    .spike_counts(spike_counts), .winner(winner), .busy(busy)
  );

  // Narrow-counter copy sharing the same stimulus, to exercise saturation.
  snn_timestep_scheduler #(.OUTPUTS(8), .COUNT_BITS(4), .STEPS_BITS(8), .PIPE_DEPTH(P)) dut_sat (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(s_start_ready),
    .num_steps(num_steps), .abort(abort), .execute(s_execute), .clear_state(s_clear_state),
    .spikes(spikes), .result_valid(s_result_valid), .result_ready(result_ready),
    .spike_counts(s_spike_counts), .winner(s_winner), .busy(s_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] c;
    logic [2:0]  w;
    logic [31:0] sc;
    logic [2:0]  sw;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] pat [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [63:0] c, input logic [2:0] w,
                              input logic [31:0] sc, input logic [2:0] sw);
    exp_t e;
    e.name = nm; e.c = c; e.w = w; e.sc = sc; e.sw = sw;
    return e;
  endfunction

  // Monitor: compares whenever a result is handed over.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got counts %0h expected none", spike_counts);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, ".counts"},   spike_counts,   e.c);
        chk({e.name, ".winner"},   64'(winner),    64'(e.w));
        chk({e.name, ".s_counts"}, 64'(s_spike_counts), 64'(e.sc));
        chk({e.name, ".s_winner"}, 64'(s_winner),  64'(e.sw));
        chk({e.name, ".s_valid"},  64'(s_result_valid), 64'd1);
      end
    end
  end

  // Issues one inference. Cycle t counts clock edges after the start handshake;
  // the network's spike for timestep k is due in cycle 2+P+k.
  task automatic do_run(input string nm, input int n, input logic [7:0] hold_sp,
                        input bit use_pat, input exp_t e, input int ready_delay);
    int t, vt, exec_cnt, clr_cnt, first_ex, last_ex, k;
    exec_cnt = 0; clr_cnt = 0; first_ex = -1; last_ex = -1; vt = -1;
    exp_q.push_back(e);
    chk({nm, ".start_ready"}, 64'(start_ready), 64'd1);
    spikes      = use_pat ? 8'h00 : hold_sp;
    start_valid = 1'b1;
    num_steps   = 8'(n);
    @(posedge clk); #1;
    start_valid = 1'b0;
    t = 1;
    for (int guard = 0; guard < 400; guard++) begin
      k = t - 2 - P;
      if (use_pat) spikes = (k >= 0 && k < n) ? pat[k] : 8'h00;
      @(negedge clk);
      if (execute) begin
        exec_cnt++;
        if (first_ex < 0) first_ex = t;
        last_ex = t;
      end
      if (clear_state) clr_cnt++;
      if (result_valid) begin
        vt = t;
        break;
      end
      @(posedge clk); #1;
      t++;
    end
    if (vt < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: got no result_valid expected one within 400 cycles", nm);
      void'(exp_q.pop_back());
      reset = 1'b1; #2; reset = 1'b0;
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < ready_delay; i++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_valid"},  64'(result_valid), 64'd1);
      chk({nm, ".hold_sready"}, 64'(start_ready),  64'd0);
      chk({nm, ".hold_counts"}, spike_counts,      e.c);
      chk({nm, ".hold_winner"}, 64'(winner),       64'(e.w));
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    spikes = 8'h00;
    chk({nm, ".busy_after"},  64'(busy),         64'd0);
    chk({nm, ".valid_after"}, 64'(result_valid), 64'd0);
    chk({nm, ".exec_cycles"}, 64'(exec_cnt),     64'(n));
    chk({nm, ".clear_pulses"}, 64'(clr_cnt),     (n > 0) ? 64'd1 : 64'd0);
    if (n > 0) begin
      chk({nm, ".exec_contig"}, 64'(last_ex - first_ex + 1), 64'(n));
      chk({nm, ".latency"},     64'(vt - last_ex),          64'(P + 1));
    end else begin
      chk({nm, ".zero_valid_cycle"}, 64'(vt), 64'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.execute",      64'(execute),      64'd0);
    chk("rst.clear_state",  64'(clear_state),  64'd0);
    chk("rst.result_valid", 64'(result_valid), 64'd0);
    chk("rst.counts",       spike_counts,      64'd0);
    chk("rst.winner",       64'(winner),       64'd0);
    chk("rst.busy",         64'(busy),         64'd0);
    chk("rst.start_ready",  64'(start_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    do_run("steps5", 5, 8'h08, 1'b0,
           mk("steps5", 64'h00000000_05000000, 3'd3, 32'h0000_5000, 3'd3), 0);

    // Counts [2,7,7,1,0,0,0,0]
    pat[0] = 8'b0000_1111;
    pat[1] = 8'b0000_0111;
    for (int i = 2; i < 7; i++) pat[i] = 8'b0000_0110;
    do_run("tie", 7, 8'h00, 1'b1,
           mk("tie", 64'h00000000_01070702, 3'd1, 32'h0000_1772, 3'd1), 0);

    do_run("sat", 255, 8'hFF, 1'b0,
           mk("sat", {8{8'(COUNT_MAX)}}, 3'd0, 32'hFFFF_FFFF, 3'd0), 0);

    do_run("zero", 0, 8'h00, 1'b0,
           mk("zero", 64'd0, 3'd0, 32'd0, 3'd0), 0);

    do_run("hold", 3, 8'h80, 1'b0,
           mk("hold", 64'h03000000_00000000, 3'd7, 32'h3000_0000, 3'd7), 10);

    // Abort on the third RUN cycle
    spikes      = 8'h01;
    num_steps   = 8'd10;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort.exec_before", 64'(execute), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.execute",     64'(execute),           64'd0);
    chk("abort.busy",        64'(busy),              64'd0);
    chk("abort.start_ready", 64'(start_ready),       64'd1);
    chk("abort.valid",       64'(result_valid),      64'd0);
    chk("abort.partial",     64'(spike_counts[7:0]), 64'd1);

    do_run("after_abort", 2, 8'h01, 1'b0,
           mk("after_abort", 64'h00000000_00000002, 3'd0, 32'h0000_0002, 3'd0), 0);

    // Async reset in the middle of RUN
    spikes      = 8'hFF;
    num_steps   = 8'd10;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mreset.exec_before",   64'(execute),   64'd1);
    chk("mreset.counts_before", spike_counts,   64'h01010101_01010101);
    #2;
    reset = 1'b1;
    #1;
    chk("mreset.execute", 64'(execute),      64'd0);
    chk("mreset.busy",    64'(busy),         64'd0);
    chk("mreset.counts",  spike_counts,      64'd0);
    chk("mreset.valid",   64'(result_valid), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    spikes = 8'h00;
    @(posedge clk); #1;

    chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
